cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Two-to-one bus arbiter that sits directly downstream of the CPU. It merges the instruction-bus and data-bus master ports onto a single memory/peripheral bus that uses the same request/ready handshake. Arbitration is round-robin, and each grant is held for one complete transaction. A watchdog counter terminates any transaction that the downstream bus never acknowledges.

## Interface
Parameters:
- TIMEOUT, 1024: cycles a granted transaction may wait for `i_bus_ready` before being force-completed; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hFFFF_FFFF: read data returned to the master on a forced completion.

Ports:
- `i_clock`  in  1  sole clock; all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `i_clock`.
- `i_ibus_request`  in  1  instruction master request; held until ready seen.
- `o_ibus_ready`  out  1  one-cycle completion strobe to instruction master.
- `i_ibus_address`  in  32  instruction fetch address; stable while requesting.
- `o_ibus_rdata`  out  32  read data, valid when `o_ibus_ready`.
- `i_dbus_rw`  in  1  data master direction, 1 = write.
- `i_dbus_request`  in  1  data master request.
- `o_dbus_ready`  out  1  completion strobe to data master.
- `i_dbus_address`  in  32  data address.
- `o_dbus_rdata`  out  32  read data, valid when `o_dbus_ready`.
- `i_dbus_wdata`  in  32  write data.
- `o_bus_rw`  out  1  merged bus direction (instruction grant always 0).
- `o_bus_request`  out  1  merged bus request.
- `i_bus_ready`  in  1  downstream completion strobe.
- `o_bus_address`  out  32  merged address.
- `i_bus_rdata`  in  32  downstream read data.
- `o_bus_wdata`  out  32  merged write data.
- `o_grant`  out  2  debug: 2'b00 idle, 2'b01 instruction, 2'b10 data.
- `o_fault`  out  1  sticky: set on any watchdog expiry, cleared only by reset.

## Operation
- States:
  - IDLE: no grant active.
  - GRANT_I: instruction master owns the bus.
  - GRANT_D: data master owns the bus.
- IDLE with one request: grant that master.
- IDLE with both requests: grant the master not granted last (`last_grant` register, reset value = data, so instruction wins the first tie).
- On grant, register `o_bus_address`, `o_bus_wdata` and `o_bus_rw` from the winner. Set `o_bus_request` = 1.
- Bus outputs are frozen for the whole grant. Input changes from either master during a grant are ignored.
- In GRANT_x with `i_bus_ready` = 1:
  - Combinationally, that cycle: `o_x_ready` = 1 and `o_x_rdata` = `i_bus_rdata`.
  - Next cycle: state → IDLE, `o_bus_request` = 0, `last_grant` = x.
- `o_x_rdata` equals `i_bus_rdata` whenever x is granted, and 0 otherwise. The non-granted ready is always 0.
- Watchdog (TIMEOUT > 0):
  - Counter clears on grant and increments each grant cycle without ready.
  - When it reaches TIMEOUT−1 without ready: `o_x_ready` = 1 and `o_x_rdata` = TIMEOUT_RDATA that cycle. `o_fault` is set.
  - Next cycle: state → IDLE, as for a normal completion.
  - If `i_bus_ready` arrives in the expiry cycle, the real completion wins and `o_fault` is not set.
- Masters drop request the cycle after seeing ready. A request still high in IDLE is treated as a new transaction.
- Reset values: state IDLE, every output 0 (`o_bus_request`, `o_bus_rw`, `o_bus_address`, `o_bus_wdata`, both readies, both rdata, `o_grant`, `o_fault`), counter 0.
- Reset asserted mid-transaction abandons it: outputs return to 0 in the next cycle and no ready is issued to the master.

## Timing
- Request sampled in IDLE at edge N → `o_bus_request` = 1 in cycle N+1. Minimum arbitration latency is 1 cycle.
- Ready path: `i_bus_ready` → `o_x_ready` is combinational, zero cycles.
- Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- Ready in cycle M → IDLE in M+1 → next grant's `o_bus_request` = 1 in M+2.
- Forced completion occurs exactly TIMEOUT cycles after `o_bus_request` first rises.

## Structure
- Shared package `CPU_BusArbiter_Types`: enum `bus_arb_state_t` {IDLE, GRANT_I, GRANT_D}; `GRANT_NONE`/`GRANT_I`/`GRANT_D` 2-bit constants.
- Single module, no sub-module.
- Watchdog counter width is $clog2(TIMEOUT+1), inline.

## Test plan
- Reset low for 3 cycles with both requests high → all outputs 0. First grant after release goes to instruction (`o_grant` = 01), address from `i_ibus_address`.
- Instruction read of 0x100, downstream ready 3 cycles later with rdata 0xCAFEF00D → `o_ibus_ready` pulses once with 0xCAFEF00D; `o_dbus_ready` stays 0.
- Both masters requesting continuously → grants alternate I, D, I, D. Data write to 0x2000 of 0x12345678 appears with `o_bus_rw` = 1 and stable for its full grant.
- TIMEOUT = 8, downstream never ready → `o_dbus_ready` 8 cycles after request rise, rdata 0xFFFFFFFF, `o_fault` = 1 and stays 1. Next transaction completes normally.
- Ready arriving exactly in the expiry cycle → normal rdata returned, `o_fault` stays 0.
- Reset pulsed during GRANT_D → no ready issued; state IDLE and outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU instruction/data bus arbiter.
// State encodings double as the o_grant debug encoding.
package CPU_BusArbiter_Types;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } bus_arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Round-robin 2:1 merge of CPU ibus/dbus onto one request/ready bus; 1-cycle grant latency,
// zero-cycle ready return, grant held until downstream ready or watchdog expiry.
import CPU_BusArbiter_Types::*;

module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_ibus_request,
  output logic        o_ibus_ready,
  input  logic [31:0] i_ibus_address,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_rw,
  input  logic        i_dbus_request,
  output logic        o_dbus_ready,
  input  logic [31:0] i_dbus_address,
  output logic [31:0] o_dbus_rdata,
  input  logic [31:0] i_dbus_wdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic [1:0]  o_grant,
  output logic        o_fault
);

  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic          WD_ON    = (TIMEOUT > 0);

  bus_arb_state_t state;
  logic           last_is_d;
  logic [CW-1:0]  wd_cnt;
  logic           bus_request_q;
  logic           bus_rw_q;
  logic [31:0]    bus_address_q;
  logic [31:0]    bus_wdata_q;
  logic           fault_q;

  logic        granted;
  logic        wd_expire;
  logic        forced;
  logic        done;
  logic        pick_d;
  logic [31:0] done_rdata;

  assign granted    = (state == GRANT_I) || (state == GRANT_D);
  assign wd_expire  = WD_ON && granted && (wd_cnt == CNT_LAST);
  assign forced     = wd_expire && !i_bus_ready;
  assign done       = granted && (i_bus_ready || wd_expire);
  assign done_rdata = forced ? TIMEOUT_RDATA : i_bus_rdata;

  // On a tie the master that did not win last time goes next.
  assign pick_d = i_dbus_request && (!i_ibus_request || !last_is_d);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state         <= IDLE;
      last_is_d     <= 1'b1;
      wd_cnt        <= '0;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= 32'd0;
      bus_wdata_q   <= 32'd0;
      fault_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (i_ibus_request || i_dbus_request) begin
            state         <= pick_d ? GRANT_D : GRANT_I;
            bus_request_q <= 1'b1;
            bus_rw_q      <= pick_d && i_dbus_rw;
            bus_address_q <= pick_d ? i_dbus_address : i_ibus_address;
            bus_wdata_q   <= pick_d ? i_dbus_wdata : 32'd0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (done) begin
            state         <= IDLE;
            bus_request_q <= 1'b0;
            last_is_d     <= (state == GRANT_D);
            wd_cnt        <= '0;
            if (forced) begin
              fault_q <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus_request_q <= 1'b0;
          wd_cnt        <= '0;
        end
      endcase
    end
  end

  // Completion strobes are suppressed while reset is asserted so an abandoned
  // transaction never reports back to its master.
  assign o_ibus_ready = i_reset && (state == GRANT_I) && done;
  assign o_dbus_ready = i_reset && (state == GRANT_D) && done;
  assign o_ibus_rdata = (i_reset && (state == GRANT_I)) ? done_rdata : 32'd0;
  assign o_dbus_rdata = (i_reset && (state == GRANT_D)) ? done_rdata : 32'd0;

  assign o_bus_request = bus_request_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_address_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_grant       = state;
  assign o_fault       = fault_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with a transaction-level reference model.
module tb_cpu_bus_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] TRD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ireq, dreq, drw, bus_ready;
  logic [31:0] iaddr, daddr, dwdata, bus_rdata;
  logic        o_ibus_ready, o_dbus_ready, o_bus_rw, o_bus_request, o_fault;
  logic [31:0] o_ibus_rdata, o_dbus_rdata, o_bus_address, o_bus_wdata;
  logic [1:0]  o_grant;

  cpu_bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_RDATA(TRD)) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_ibus_request (ireq),
    .o_ibus_ready   (o_ibus_ready),
    .i_ibus_address (iaddr),
    .o_ibus_rdata   (o_ibus_rdata),
    .i_dbus_rw      (drw),
    .i_dbus_request (dreq),
    .o_dbus_ready   (o_dbus_ready),
    .i_dbus_address (daddr),
    .o_dbus_rdata   (o_dbus_rdata),
    .i_dbus_wdata   (dwdata),
    .o_bus_rw       (o_bus_rw),
    .o_bus_request  (o_bus_request),
    .i_bus_ready    (bus_ready),
    .o_bus_address  (o_bus_address),
    .i_bus_rdata    (bus_rdata),
    .o_bus_wdata    (o_bus_wdata),
    .o_grant        (o_grant),
    .o_fault        (o_fault)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // Reference model: who owns the bus, how long it has waited, what it captured.
  int          m_owner = 0;   // 0 none, 1 instruction, 2 data
  int          m_age   = 0;
  int          m_last  = 2;
  bit          m_fault = 1'b0;
  bit          m_fresh = 1'b1;
  logic        m_rw    = 1'b0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_wdata = 32'd0;

  always @(posedge clk) started <= 1'b1;

  always @(negedge clk) begin : model
    logic        forced, done;
    logic [31:0] exp_rd;
    int          win;
    forced = (m_owner != 0) && (m_age == TO - 1) && !bus_ready;
    done   = (m_owner != 0) && (bus_ready || forced);
    exp_rd = forced ? TRD : bus_rdata;
    if (started) begin
      chk("m_grant", {30'd0, o_grant}, m_owner);
      chk("m_bus_request", o_bus_request, m_owner != 0);
      chk("m_ibus_ready", o_ibus_ready, rst_n && m_owner == 1 && done);
      chk("m_dbus_ready", o_dbus_ready, rst_n && m_owner == 2 && done);
      chk("m_ibus_rdata", o_ibus_rdata, (rst_n && m_owner == 1) ? exp_rd : 32'd0);
      chk("m_dbus_rdata", o_dbus_rdata, (rst_n && m_owner == 2) ? exp_rd : 32'd0);
      chk("m_fault", o_fault, m_fault);
      if (m_owner != 0 || m_fresh) begin
        chk("m_bus_address", o_bus_address, m_addr);
        chk("m_bus_rw", o_bus_rw, m_rw);
      end
      if (m_owner == 2 || m_fresh) chk("m_bus_wdata", o_bus_wdata, m_wdata);
    end
    if (!rst_n) begin
      m_owner <= 0; m_age <= 0; m_last <= 2; m_fault <= 1'b0; m_fresh <= 1'b1;
      m_rw <= 1'b0; m_addr <= 32'd0; m_wdata <= 32'd0;
    end else if (m_owner == 0) begin
      if (ireq || dreq) begin
        win = (ireq && dreq) ? ((m_last == 1) ? 2 : 1) : (ireq ? 1 : 2);
        m_owner <= win;
        m_age   <= 0;
        m_fresh <= 1'b0;
        m_addr  <= (win == 2) ? daddr : iaddr;
        m_rw    <= (win == 2) ? drw : 1'b0;
        m_wdata <= dwdata;
      end
    end else if (done) begin
      if (forced) m_fault <= 1'b1;
      m_last  <= m_owner;
      m_owner <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench did not finish");
  end

  logic [1:0] seq [4];
  int n, k_hit;

  initial begin
    rst_n = 1'b0; ireq = 1'b1; iaddr = 32'h100;
    dreq = 1'b1; drw = 1'b1; daddr = 32'h2000; dwdata = 32'h1234_5678;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    cyc(3);
    chk("reset_request", o_bus_request, 0);
    chk("reset_grant", o_grant, 0);
    chk("reset_addr", o_bus_address, 0);
    chk("reset_fault", o_fault, 0);
    chk("reset_ibus_ready", o_ibus_ready, 0);
    rst_n = 1'b1;

    // First grant after reset: instruction wins the tie.
    cyc(1);
    chk("first_grant", o_grant, 2'b01);
    chk("first_addr", o_bus_address, 32'h100);
    chk("first_rw", o_bus_rw, 0);
    cyc(3);
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
    chk("ibus_ready", o_ibus_ready, 1);
    chk("ibus_rdata", o_ibus_rdata, 32'hCAFE_F00D);
    chk("dbus_ready_quiet", o_dbus_ready, 0);
    cyc(1);
    bus_ready = 1'b0; bus_rdata = 32'd0; ireq = 1'b0;
    chk("idle_after_done", o_grant, 0);

    // Data write, with master inputs wiggled during the grant.
    cyc(1);
    chk("d_grant", o_grant, 2'b10);
    chk("d_addr", o_bus_address, 32'h2000);
    chk("d_rw", o_bus_rw, 1);
    chk("d_wdata", o_bus_wdata, 32'h1234_5678);
    daddr = 32'hDEAD_0000; dwdata = 32'd0; drw = 1'b0; ireq = 1'b1; iaddr = 32'h104;
    cyc(2);
    chk("d_addr_frozen", o_bus_address, 32'h2000);
    chk("d_wdata_frozen", o_bus_wdata, 32'h1234_5678);
    chk("d_rw_frozen", o_bus_rw, 1);
    bus_ready = 1'b1; #1;
    chk("dbus_ready", o_dbus_ready, 1);
    chk("ibus_ready_quiet", o_ibus_ready, 0);
    cyc(1);
    bus_ready = 1'b0; daddr = 32'h3000;

    // Both masters requesting continuously: strict alternation.
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      cyc(1);
      bus_ready = 1'b0;
      if (o_bus_request) begin
        seq[n] = o_grant;
        n++;
        bus_ready = 1'b1;
      end
    end
    chk("alt_count", n, 4);
    if (n == 4) begin
      chk("alt_0", seq[0], 2'b01);
      chk("alt_1", seq[1], 2'b10);
      chk("alt_2", seq[2], 2'b01);
      chk("alt_3", seq[3], 2'b10);
    end
    cyc(1);
    bus_ready = 1'b0; ireq = 1'b0; dreq = 1'b0;
    cyc(1);

    // Watchdog: downstream never answers.
    dreq = 1'b1; drw = 1'b0; daddr = 32'h4000;
    k_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (o_dbus_ready) begin
        k_hit = k;
        break;
      end
    end
    chk("wd_latency", k_hit, 8);
    chk("wd_rdata", o_dbus_rdata, 32'hFFFF_FFFF);
    chk("wd_fault_before", o_fault, 0);
    cyc(1);
    dreq = 1'b0; ireq = 1'b1; iaddr = 32'h200;
    chk("wd_fault_set", o_fault, 1);
    cyc(2);
    bus_ready = 1'b1; bus_rdata = 32'h600D_F00D; #1;
    chk("post_wd_ready", o_ibus_ready, 1);
    chk("post_wd_rdata", o_ibus_rdata, 32'h600D_F00D);
    cyc(1);
    bus_ready = 1'b0; ireq = 1'b0;
    chk("fault_sticky", o_fault, 1);
    cyc(1);

    // Reset during a data grant abandons it.
    dreq = 1'b1; drw = 1'b1; daddr = 32'h5000; dwdata = 32'hA5A5_A5A5;
    cyc(1);
    chk("rst_d_grant", o_grant, 2'b10);
    cyc(1);
    rst_n = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h1111_1111; #1;
    chk("rst_no_ready", o_dbus_ready, 0);
    chk("rst_no_rdata", o_dbus_rdata, 0);
    cyc(1);
    chk("rst_grant", o_grant, 0);
    chk("rst_request", o_bus_request, 0);
    chk("rst_addr", o_bus_address, 0);
    chk("rst_wdata", o_bus_wdata, 0);
    chk("rst_fault", o_fault, 0);
    rst_n = 1'b1; bus_ready = 1'b0; dreq = 1'b0;
    cyc(1);

    // Ready lands exactly in the expiry cycle: real completion wins.
    dreq = 1'b1; drw = 1'b0; daddr = 32'h6000;
    cyc(8);
    bus_ready = 1'b1; bus_rdata = 32'h55AA_55AA; #1;
    chk("race_ready", o_dbus_ready, 1);
    chk("race_rdata", o_dbus_rdata, 32'h55AA_55AA);
    cyc(1);
    bus_ready = 1'b0; dreq = 1'b0;
    chk("race_no_fault", o_fault, 0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
